mem_access_seq: RTL and testbench

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

---
 rtl/lc3_mem_pkg.sv | 55 +++++
 rtl/mem_access_seq.sv | 116 +++++++++++
 tb/tb_mem_access_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg -- shared definitions for the LC-3 memory-access sequencer.
//   Opcode constants for the six memory instructions, the mem_state
//   encodings seen by the memory-access stage, the FSM state type, and
//   small opcode-decode helpers.
package lc3_mem_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  localparam logic [1:0] MS_READ     = 2'd0;
  localparam logic [1:0] MS_READ_IND = 2'd1;
  localparam logic [1:0] MS_WRITE    = 2'd2;
  localparam logic [1:0] MS_IDLE     = 2'd3;

  // State values equal the mem_state code so the state register can drive
  // mem_state directly.
  typedef enum logic [1:0] {
    ST_RD   = 2'd0,
    ST_IND  = 2'd1,
    ST_WR   = 2'd2,
    ST_IDLE = 2'd3
  } mem_fsm_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    logic hit;
    case (op)
      OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: hit = 1'b1;
      default:                                       hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_load_op(input logic [3:0] op);
    logic hit;
    case (op)
      OP_LD, OP_LDR, OP_LDI: hit = 1'b1;
      default:               hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_indirect_op(input logic [3:0] op);
    logic hit;
    case (op)
      OP_LDI, OP_STI: hit = 1'b1;
      default:        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mem_access_seq.sv
// mem_access_seq -- sequences LC-3 memory instructions through the
// memory-access stage (direct read/write, or indirect via a pointer read).
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   mem_req, opcode     memory instruction presented by Execute
//   E_addr, E_data      effective address / store data from Execute
//   memout              data returned by the memory-access stage
//   mem_state           access state to memory stage (0 RD,1 RD_IND,2 WR,3 IDLE)
//   M_Control           0 = direct address, 1 = address from previous read data
//   M_Addr, M_Data      access address / store data latched at acceptance
//   mem_busy            stall to upstream while a sequence is in flight
//   mem_done            one-cycle completion pulse
//   ld_data             last completed load result
module mem_access_seq
  import lc3_mem_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_req,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] E_addr,
  input  logic [WIDTH-1:0] E_data,
  input  logic [WIDTH-1:0] memout,
  output logic [1:0]       mem_state,
  output logic             M_Control,
  output logic [WIDTH-1:0] M_Addr,
  output logic [WIDTH-1:0] M_Data,
  output logic             mem_busy,
  output logic             mem_done,
  output logic [WIDTH-1:0] ld_data
);

  mem_fsm_e         state_r;
  mem_fsm_e         state_next_s;
  logic             accept_s;
  logic             is_load_r;
  logic             ctrl_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] addr_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] ld_r;

  // Next-state decode and request acceptance.
  always_comb begin
    accept_s     = 1'b0;
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_req && is_mem_op(opcode)) begin
          accept_s = 1'b1;
          if (is_indirect_op(opcode)) begin
            state_next_s = ST_IND;
          end else if (is_load_op(opcode)) begin
            state_next_s = ST_RD;
          end else begin
            state_next_s = ST_WR;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      // The pointer read is done; finish with the access the opcode asked for.
      ST_IND: begin
        if (is_load_r) begin
          state_next_s = ST_RD;
        end else begin
          state_next_s = ST_WR;
        end
      end
      ST_RD:   state_next_s = ST_IDLE;
      ST_WR:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, output and capture registers; reset wins over everything,
  // so an aborted sequence produces neither mem_done nor a load capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      is_load_r <= 1'b0;
      ctrl_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      addr_r    <= {WIDTH{1'b0}};
      data_r    <= {WIDTH{1'b0}};
      ld_r      <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      // Only the access that follows the pointer read uses the read data as address.
      ctrl_r  <= (state_r == ST_IND);
      done_r  <= (state_r == ST_RD) || (state_r == ST_WR);
      if (accept_s) begin
        addr_r    <= E_addr;
        data_r    <= E_data;
        is_load_r <= is_load_op(opcode);
      end
      if (state_r == ST_RD) begin
        ld_r <= memout;
      end
    end
  end

  assign mem_state = state_r;
  assign M_Control = ctrl_r;
  assign M_Addr    = addr_r;
  assign M_Data    = data_r;
  assign mem_busy  = busy_r;
  assign mem_done  = done_r;
  assign ld_data   = ld_r;

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq -- self-checking bench for mem_access_seq.
//   A transaction-level model turns each accepted instruction into the list
//   of per-cycle outputs it must produce; a compare process checks every
//   cycle. Directed scenarios add hand-computed literal expectations.
module tb_mem_access_seq;

  localparam logic [1:0] C_READ  = 2'd0;
  localparam logic [1:0] C_RIND  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_IDLE  = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0;
  logic [3:0]  opcode = 4'b0000;
  logic [15:0] E_addr = 16'h0000;
  logic [15:0] E_data = 16'h0000;
  logic [15:0] memout = 16'h0000;
  logic [1:0]  mem_state;
  logic        M_Control;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic        mem_busy;
  logic        mem_done;
  logic [15:0] ld_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_seq #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .opcode(opcode),
    .E_addr(E_addr), .E_data(E_data), .memout(memout),
    .mem_state(mem_state), .M_Control(M_Control), .M_Addr(M_Addr),
    .M_Data(M_Data), .mem_busy(mem_busy), .mem_done(mem_done), .ld_data(ld_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [1:0] ms;
    logic       ctl;
    logic       busy;
    logic       done;
  } step_t;

  step_t       sched[$];
  logic [1:0]  e_ms   = C_IDLE;
  logic        e_ctl  = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic [15:0] e_addr = 16'h0000;
  logic [15:0] e_data = 16'h0000;
  logic [15:0] e_ld   = 16'h0000;

  always @(posedge clock) begin
    step_t nxt;
    logic  known, indirect, is_store;
    if (reset) begin
      sched.delete();
      e_ms = C_IDLE; e_ctl = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_addr = 16'h0000; e_data = 16'h0000; e_ld = 16'h0000;
    end else begin
      // a READ cycle ending now delivers memout as the load result
      if (e_ms == C_READ) e_ld = memout;
      nxt = '{C_IDLE, 1'b0, 1'b0, 1'b0};
      known = 1'b1; indirect = 1'b0; is_store = 1'b0;
      case (opcode)
        4'b0010, 4'b0110: begin indirect = 1'b0; is_store = 1'b0; end
        4'b0011, 4'b0111: begin indirect = 1'b0; is_store = 1'b1; end
        4'b1010:          begin indirect = 1'b1; is_store = 1'b0; end
        4'b1011:          begin indirect = 1'b1; is_store = 1'b1; end
        default:          known = 1'b0;
      endcase
      if (mem_req && !e_busy && known) begin
        e_addr = E_addr;
        e_data = E_data;
        if (indirect) sched.push_back('{C_RIND, 1'b0, 1'b1, 1'b0});
        sched.push_back('{(is_store ? C_WRITE : C_READ), indirect, 1'b1, 1'b0});
        sched.push_back('{C_IDLE, 1'b0, 1'b0, 1'b1});
      end
      if (sched.size() > 0) nxt = sched.pop_front();
      e_ms = nxt.ms; e_ctl = nxt.ctl; e_busy = nxt.busy; e_done = nxt.done;
    end
    #1;
    chk("mem_state", {30'd0, mem_state}, {30'd0, e_ms});
    chk("M_Control", {31'd0, M_Control}, {31'd0, e_ctl});
    chk("mem_busy",  {31'd0, mem_busy},  {31'd0, e_busy});
    chk("mem_done",  {31'd0, mem_done},  {31'd0, e_done});
    chk("M_Addr",    {16'd0, M_Addr},    {16'd0, e_addr});
    chk("M_Data",    {16'd0, M_Data},    {16'd0, e_data});
    chk("ld_data",   {16'd0, ld_data},   {16'd0, e_ld});
  end

  // ---------------- directed stimulus ----------------
  // Present one instruction, hold it while busy, feed memout per access
  // state, and check latency, observed state/control sequence and result.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] ind_v, input logic [15:0] rd_v,
                        input int exp_lat, input logic [1:0] es1, input logic [1:0] es2,
                        input logic ec1, input logic ec2, input logic [15:0] exp_ld);
    int lat;
    logic [1:0] s1, s2;
    logic c1, c2;
    @(negedge clock);
    mem_req = 1'b1; opcode = op; E_addr = a; E_data = d; memout = ind_v;
    lat = 0; s1 = 2'd0; s2 = 2'd0; c1 = 1'b0; c2 = 1'b0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin s1 = mem_state; c1 = M_Control; end
      if (lat == 2) begin s2 = mem_state; c2 = M_Control; end
      mem_req = mem_busy;
      memout  = (mem_state == C_RIND) ? ind_v : rd_v;
    end while (!mem_done && lat < 10);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_state1"}, {30'd0, s1}, {30'd0, es1});
    chk({nm, "_state2"}, {30'd0, s2}, {30'd0, es2});
    chk({nm, "_ctrl1"}, {31'd0, c1}, {31'd0, ec1});
    chk({nm, "_ctrl2"}, {31'd0, c2}, {31'd0, ec2});
    chk({nm, "_M_Addr"}, {16'd0, M_Addr}, {16'd0, a});
    chk({nm, "_ld_data"}, {16'd0, ld_data}, {16'd0, exp_ld});
    mem_req = 1'b0;
  endtask

  initial begin
    int wait_cnt;
    repeat (2) @(negedge clock);
    chk("reset_state", {30'd0, mem_state}, 32'd3);
    chk("reset_busy", {31'd0, mem_busy}, 32'd0);
    chk("reset_ld", {16'd0, ld_data}, 32'd0);
    chk("reset_addr", {16'd0, M_Addr}, 32'd0);

    // reset has priority over a simultaneous request
    mem_req = 1'b1; opcode = 4'b0010; E_addr = 16'h1111;
    @(negedge clock);
    chk("rst_prio_state", {30'd0, mem_state}, 32'd3);
    chk("rst_prio_addr", {16'd0, M_Addr}, 32'd0);
    reset = 1'b0; mem_req = 1'b0;

    // non-memory opcode is ignored
    mem_req = 1'b1; opcode = 4'b0001; E_addr = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("nonmem_state", {30'd0, mem_state}, 32'd3);
      chk("nonmem_busy", {31'd0, mem_busy}, 32'd0);
      chk("nonmem_done", {31'd0, mem_done}, 32'd0);
    end
    mem_req = 1'b0;

    // reset in the IND cycle of an LDI aborts it
    @(negedge clock);
    mem_req = 1'b1; opcode = 4'b1010; E_addr = 16'h3050; memout = 16'h4000;
    @(negedge clock);
    chk("abort_ind_in_ind", {30'd0, mem_state}, 32'd1);
    mem_req = 1'b0; reset = 1'b1; memout = 16'h7777;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ind_state", {30'd0, mem_state}, 32'd3);
    chk("abort_ind_done", {31'd0, mem_done}, 32'd0);
    chk("abort_ind_ld", {16'd0, ld_data}, 32'd0);
    @(negedge clock);
    chk("abort_ind_late_done", {31'd0, mem_done}, 32'd0);

    // reset in the RD cycle of an LD: no capture, no completion
    mem_req = 1'b1; opcode = 4'b0110; E_addr = 16'h3060;
    @(negedge clock);
    chk("abort_rd_in_rd", {30'd0, mem_state}, 32'd0);
    mem_req = 1'b0; reset = 1'b1; memout = 16'hDEAD;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_rd_ld", {16'd0, ld_data}, 32'd0);
    @(negedge clock);
    chk("abort_rd_late_done", {31'd0, mem_done}, 32'd0);

    // reset in the WR cycle of an ST
    mem_req = 1'b1; opcode = 4'b0011; E_addr = 16'h3070; E_data = 16'h1234;
    @(negedge clock);
    chk("abort_wr_in_wr", {30'd0, mem_state}, 32'd2);
    mem_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_wr_state", {30'd0, mem_state}, 32'd3);
    @(negedge clock);
    chk("abort_wr_late_done", {31'd0, mem_done}, 32'd0);

    // main sequences
    run_op("ld",  4'b0010, 16'h3010, 16'h0000, 16'hBEEF, 16'hBEEF, 2, 2'd0, 2'd3, 1'b0, 1'b0, 16'hBEEF);
    run_op("ldi", 4'b1010, 16'h3020, 16'h0000, 16'h4000, 16'h1234, 3, 2'd1, 2'd0, 1'b0, 1'b1, 16'h1234);
    run_op("sti", 4'b1011, 16'h3030, 16'h00AA, 16'h5000, 16'h9999, 3, 2'd1, 2'd2, 1'b0, 1'b1, 16'h1234);
    chk("sti_M_Data", {16'd0, M_Data}, 32'h00AA);

    // back-to-back: ST held while busy, LD presented as soon as busy falls
    @(negedge clock);
    mem_req = 1'b1; opcode = 4'b0011; E_addr = 16'h3040; E_data = 16'h5555;
    wait_cnt = 0;
    do begin
      @(negedge clock);
      wait_cnt++;
    end while (mem_busy && wait_cnt < 10) ;
    chk("b2b_wait", {31'd0, mem_busy}, 32'd0);
    chk("b2b_st_done", {31'd0, mem_done}, 32'd1);
    chk("b2b_st_data", {16'd0, M_Data}, 32'h5555);
    opcode = 4'b0010; E_addr = 16'h3040; E_data = 16'h0000; memout = 16'hA5A5;
    @(negedge clock);
    chk("b2b_ld_accepted", {30'd0, mem_state}, 32'd0);
    mem_req = 1'b0;
    @(negedge clock);
    chk("b2b_ld_done", {31'd0, mem_done}, 32'd1);
    chk("b2b_ld_data", {16'd0, ld_data}, 32'hA5A5);
    @(negedge clock);
    chk("b2b_no_extra", {30'd0, mem_state}, 32'd3);
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
